dt_res_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port 16384×8 distance-transform result RAM among three requesters:
- forward-pass engine (port 0)
- backward-pass engine (port 1)
- host readback/DMA port (port 2)

It sits between the engines and the RAM pins (res_rd, res_wr, res_addr, res_do, res_di). It registers all RAM-side signals, returns read data with a fixed latency, and supports lock bursts so an engine can finish a neighbourhood read-modify-write without interleaving.

---
 rtl/dt_pkg.sv | 23 ++
 rtl/dt_rr_pick.sv | 30 +++
 rtl/dt_res_arbiter.sv | 159 +++++++++++++++
 tb/tb_dt_res_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared definitions for the distance-transform result-RAM blocks:
// RAM geometry, requester port indices and the arbiter state encoding.
package dt_pkg;

  localparam int AW     = 14;
  localparam int DW     = 8;
  localparam int NPORT  = 3;

  localparam int P_FWD  = 0;
  localparam int P_BWD  = 1;
  localparam int P_HOST = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // One-hot (3-bit) to port index; zero maps to port 0.
  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    return {oh[2], oh[1]};
  endfunction

endpackage

// File: rtl/dt_rr_pick.sv
// Combinational round-robin pick over three requesters: the search starts at
// (last_owner+1) mod 3, so last_owner itself has the lowest priority.
module dt_rr_pick (
  input  logic [2:0] req,
  input  logic [1:0] last_owner,
  output logic [2:0] winner
);

  always_comb begin
    winner = 3'b000;
    case (last_owner)
      2'd0: begin
        if      (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
        else if (req[0]) winner = 3'b001;
      end
      2'd1: begin
        if      (req[2]) winner = 3'b100;
        else if (req[0]) winner = 3'b001;
        else if (req[1]) winner = 3'b010;
      end
      default: begin
        if      (req[0]) winner = 3'b001;
        else if (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/dt_res_arbiter.sv
// Round-robin arbiter sharing the single-port DT result RAM between the forward
// engine, backward engine and host port, with lock bursts and fixed read latency.
//
// Handshake: req[i] is a level request; an access is transferred in every cycle
// where gnt[i]=1 and req[i]=1. There is no back-pressure on responses: rvalid[i]
// is a single-cycle pulse exactly 3 cycles after the granted read cycle.
module dt_res_arbiter #(
  parameter int AW       = dt_pkg::AW,
  parameter int DW       = dt_pkg::DW,
  parameter int MAXBURST = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      lock,
  input  logic [2:0]      wr,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            res_rd,
  output logic            res_wr,
  output logic [AW-1:0]   res_addr,
  output logic [DW-1:0]   res_do,
  input  logic [DW-1:0]   res_di
);
  import dt_pkg::*;

  arb_state_t state, state_nxt;
  logic [1:0] owner, last_owner, last_nxt, pick_base;
  logic [2:0] gnt_nxt, winner;
  logic [7:0] burst_cnt, burst_nxt;
  logic       own_req, own_lock, others, burst_done, release_own;

  logic          access, acc_wr;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  logic       tag1_v, tag2_v;
  logic [1:0] tag1_p, tag2_p;

  // When the owner releases, it becomes the base of the search so that a
  // re-request from it is considered last.
  assign pick_base = (state == OWN) ? owner : last_owner;

  dt_rr_pick u_pick (
    .req        (req),
    .last_owner (pick_base),
    .winner     (winner)
  );

  assign own_req     = |(req & gnt);
  assign own_lock    = |(lock & gnt);
  assign others      = |(req & ~gnt);
  assign burst_done  = burst_cnt >= 8'(MAXBURST - 1);
  assign release_own = (state == OWN) && !own_lock &&
                       (!own_req || (others && burst_done));

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last_owner;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = OWN;
          gnt_nxt   = winner;
          burst_nxt = 8'd0;
        end
      end
      OWN: begin
        if (release_own) begin
          last_nxt  = owner;
          burst_nxt = 8'd0;
          if (|req) begin
            gnt_nxt = winner;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 3'b000;
          end
        end else if (burst_cnt != 8'hFF) begin
          burst_nxt = burst_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gnt        <= 3'b000;
      owner      <= 2'd0;
      last_owner <= 2'd2;
      burst_cnt  <= 8'd0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      owner      <= oh2idx(gnt_nxt);
      last_owner <= last_nxt;
      burst_cnt  <= burst_nxt;
    end
  end

  // Current owner's access fields.
  assign access = own_req;
  assign acc_wr = |(wr & gnt);

  always_comb begin
    acc_addr  = addr[P_HOST*AW +: AW];
    acc_wdata = wdata[P_HOST*DW +: DW];
    case (owner)
      2'(P_FWD): begin
        acc_addr  = addr[P_FWD*AW +: AW];
        acc_wdata = wdata[P_FWD*DW +: DW];
      end
      2'(P_BWD): begin
        acc_addr  = addr[P_BWD*AW +: AW];
        acc_wdata = wdata[P_BWD*DW +: DW];
      end
      default: ;
    endcase
  end

  // RAM pins and read-tag pipeline: tag1 lines up with res_rd, tag2 with res_di.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_rd   <= 1'b0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
      tag1_v   <= 1'b0;
      tag1_p   <= 2'd0;
      tag2_v   <= 1'b0;
      tag2_p   <= 2'd0;
      rvalid   <= 3'b000;
      rdata    <= '0;
    end else begin
      res_rd <= access && !acc_wr;
      res_wr <= access && acc_wr;
      if (access) begin
        res_addr <= acc_addr;
        res_do   <= acc_wdata;
      end
      tag1_v <= access && !acc_wr;
      tag1_p <= owner;
      tag2_v <= tag1_v;
      tag2_p <= tag1_p;
      rvalid <= tag2_v ? (3'b001 << tag2_p) : 3'b000;
      if (tag2_v) rdata <= res_di;
    end
  end

endmodule

// File: tb/tb_dt_res_arbiter.sv
// Bench for dt_res_arbiter: directed vector table, hand-written corner sequences
// and random traffic, all checked against a cycle-level arbitration/RAM model.
module tb_dt_res_arbiter;
  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int MAXB = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [2:0]      req, lock, wr;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata, res_do, res_di;
  logic            res_rd, res_wr;
  logic [AW-1:0]   res_addr;

  always #5 clk = ~clk;

  dt_res_arbiter #(.AW(AW), .DW(DW), .MAXBURST(MAXB)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wr(wr),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
    .res_di(res_di)
  );

  // RAM behind the pins: read data appears the cycle after res_rd.
  bit [7:0] ram    [0:16383];
  bit [7:0] shadow [0:16383];
  always @(posedge clk) begin
    if (res_wr) ram[res_addr] <= res_do;
    if (res_rd) res_di <= ram[res_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: owner as an int (-1 = nobody), served-cycle count.
  int            m_own, m_last, m_served;
  logic          exp_rd, exp_wr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_do, exp_rdata;
  logic [9:0]    exp_q[$];
  int            due_q[$];

  typedef struct {
    logic [2:0]    req, lock, wr;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0;
    logic [2:0]    exp_gnt, exp_rv;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] oh(input int p);
    return (p < 0) ? 3'b000 : 3'(1 << p);
  endfunction

  function automatic int rr_next(input logic [2:0] r, input int from);
    for (int k = 1; k <= 3; k++) begin
      if (r[(from + k) % 3]) return (from + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_last = 2; m_served = 0;
    exp_rd = 0; exp_wr = 0; exp_addr = '0; exp_do = '0; exp_rdata = '0;
    exp_q.delete(); due_q.delete();
  endtask

  task automatic model_step();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_rd = 0; exp_wr = 0;
    if (m_own >= 0 && req[m_own]) begin
      a = addr[m_own*AW +: AW];
      d = wdata[m_own*DW +: DW];
      exp_addr = a; exp_do = d;
      if (wr[m_own]) begin
        exp_wr = 1; shadow[a] = d;
      end else begin
        exp_rd = 1;
        exp_q.push_back({2'(m_own), shadow[a]});
        due_q.push_back(cyc + 3);
      end
    end
    if (m_own < 0) begin
      if (req != 0) begin m_own = rr_next(req, m_last); m_served = 0; end
    end else begin
      m_served++;
      if (!lock[m_own] &&
          (!req[m_own] || (((req & ~oh(m_own)) != 0) && m_served >= MAXB))) begin
        m_last = m_own;
        m_own = (req != 0) ? rr_next(req, m_own) : -1;
        m_served = 0;
      end
    end
  endtask

  // Called at the falling edge: compare this cycle's outputs, then advance.
  task automatic model_cycle();
    logic [2:0] exp_rv;
    logic [9:0] e;
    exp_rv = 3'b000;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      e = exp_q.pop_front();
      exp_rv = oh(int'(e[9:8]));
      exp_rdata = e[7:0];
    end
    chk("gnt", gnt, oh(m_own));
    chk("rvalid", rvalid, exp_rv);
    chk("rdata", rdata, exp_rdata);
    chk("res_rd", res_rd, exp_rd);
    chk("res_wr", res_wr, exp_wr);
    chk("res_addr", res_addr, exp_addr);
    chk("res_do", res_do, exp_do);
    if (reset) model_step();
    cyc++;
  endtask

  task automatic finish_cycle();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    req = 0; lock = 0; wr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      finish_cycle();
    end
  endtask

  task automatic do_reset();
    reset = 0;
    req = 0; lock = 0; wr = 0; addr = '0; wdata = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      finish_cycle();
    end
    reset = 1;
  endtask

  initial begin
    req = 0; lock = 0; wr = 0; addr = '0; wdata = '0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Write then read of the same address across a handover.
    tbl[0] = '{req:3'b001, lock:3'b000, wr:3'b001, a0:14'h0081, a1:14'h0000, d0:8'h2A,
               exp_gnt:3'b000, exp_rv:3'b000, exp_rdata:8'h00};
    tbl[1] = '{req:3'b001, lock:3'b000, wr:3'b001, a0:14'h0081, a1:14'h0000, d0:8'h2A,
               exp_gnt:3'b001, exp_rv:3'b000, exp_rdata:8'h00};
    tbl[2] = '{req:3'b010, lock:3'b000, wr:3'b000, a0:14'h0000, a1:14'h0081, d0:8'h00,
               exp_gnt:3'b001, exp_rv:3'b000, exp_rdata:8'h00};
    tbl[3] = '{req:3'b010, lock:3'b000, wr:3'b000, a0:14'h0000, a1:14'h0081, d0:8'h00,
               exp_gnt:3'b010, exp_rv:3'b000, exp_rdata:8'h00};
    tbl[4] = '{req:3'b000, lock:3'b000, wr:3'b000, a0:14'h0000, a1:14'h0000, d0:8'h00,
               exp_gnt:3'b010, exp_rv:3'b000, exp_rdata:8'h00};
    tbl[5] = '{req:3'b000, lock:3'b000, wr:3'b000, a0:14'h0000, a1:14'h0000, d0:8'h00,
               exp_gnt:3'b000, exp_rv:3'b000, exp_rdata:8'h00};
    tbl[6] = '{req:3'b000, lock:3'b000, wr:3'b000, a0:14'h0000, a1:14'h0000, d0:8'h00,
               exp_gnt:3'b000, exp_rv:3'b010, exp_rdata:8'h2A};
    tbl[7] = '{req:3'b000, lock:3'b000, wr:3'b000, a0:14'h0000, a1:14'h0000, d0:8'h00,
               exp_gnt:3'b000, exp_rv:3'b000, exp_rdata:8'h2A};
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req; lock = tbl[i].lock; wr = tbl[i].wr;
      addr = {14'h0000, tbl[i].a1, tbl[i].a0};
      wdata = {8'h00, 8'h00, tbl[i].d0};
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].exp_gnt);
      chk($sformatf("tbl%0d_rvalid", i), rvalid, tbl[i].exp_rv);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
      finish_cycle();
    end

    // All three ports reading continuously: 8-cycle tenures, no gaps.
    do_reset();
    req = 3'b111; lock = 0; wr = 0;
    for (int c = 0; c < 26; c++) begin
      addr = {14'($urandom_range(0, 255)), 14'($urandom_range(0, 255)), 14'($urandom_range(0, 255))};
      @(negedge clk);
      chk("rr_tenure", gnt, (c == 0) ? 3'b000 : (c <= 8) ? 3'b001 :
                            (c <= 16) ? 3'b010 : (c <= 24) ? 3'b100 : 3'b001);
      finish_cycle();
    end

    // Locked burst of 20 reads from port 0 while port 1 waits.
    idle_cycles(3);
    req = 3'b001; lock = 3'b001;
    @(negedge clk); finish_cycle();
    req = 3'b011;
    for (int c = 0; c < 20; c++) begin
      addr = {14'h0000, 14'h0040, 14'($urandom_range(0, 255))};
      @(negedge clk);
      chk("lock_hold", gnt, 3'b001);
      finish_cycle();
    end
    req = 3'b010; lock = 3'b000;
    @(negedge clk); chk("lock_drop_same", gnt, 3'b001); finish_cycle();
    @(negedge clk); chk("lock_drop_next", gnt, 3'b010); finish_cycle();
    idle_cycles(4);

    // Reset with two reads in flight.
    req = 3'b001; wr = 0; addr = {14'h0, 14'h0, 14'h0081};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); finish_cycle();
    end
    req = 0;
    #1 reset = 0;
    #1;
    chk("arst_gnt", gnt, 3'b000);
    chk("arst_rvalid", rvalid, 3'b000);
    chk("arst_rdata", rdata, 8'h00);
    chk("arst_res_rd", res_rd, 1'b0);
    chk("arst_res_wr", res_wr, 1'b0);
    chk("arst_res_addr", res_addr, 14'h0);
    chk("arst_res_do", res_do, 8'h00);
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); finish_cycle();
    end
    reset = 1; req = 3'b111;
    @(negedge clk); chk("post_rst_idle", gnt, 3'b000); finish_cycle();
    @(negedge clk); chk("post_rst_first", gnt, 3'b001); finish_cycle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); finish_cycle();
    end

    // Random traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      lock = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      wr = 3'($urandom_range(0, 7));
      addr = {14'($urandom_range(0, 15)), 14'($urandom_range(0, 15)), 14'($urandom_range(0, 15))};
      wdata = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      @(negedge clk);
      finish_cycle();
    end
    idle_cycles(10);
    chk("reads_answered", due_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
